// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions, fetch FSM encoding, reset PC.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] Arith_Logic_cmd = 6'h00;
  localparam logic [5:0] JUMP_cmd        = 6'h02;
  localparam logic [5:0] BEQ_cmd         = 6'h04;
  localparam logic [5:0] BNE_cmd         = 6'h05;
  localparam logic [5:0] ADDI_cmd        = 6'h08;
  localparam logic [5:0] LW_cmd          = 6'h23;
  localparam logic [5:0] SW_cmd          = 6'h2B;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential, PC-relative branch, or pseudo-direct jump.
// Purely combinational, no latency, no flow control.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        pcSrc,
  input  logic        signExtSrc,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;
  logic [31:0] jump_tgt;

  // Word offset sign-extended then shifted; the add wraps naturally at 32 bits.
  assign branch_off = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (pcSrc) begin
      if (signExtSrc) next_pc = jump_tgt;
      else            next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, one outstanding req/gnt/rvalid read, holds instr until decode accepts.
// Best case 3 cycles per instruction; stalls indefinitely on gnt, rvalid or instr_ready.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcSrc,
  input  logic        signExtSrc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_t state;
  logic [31:0]  next_pc;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  next_pc_calc u_next_pc_calc (
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .pcSrc      (pcSrc),
    .signExtSrc (signExtSrc),
    .next_pc    (next_pc)
  );

  // imem_req and instr_valid are registered alongside the state so neither
  // has a combinational path from the memory handshake inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state       <= ISSUE;
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            state       <= FETCH;
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of `control_unit`. It owns the program counter and issues word reads to instruction memory over a request/grant/valid handshake. It holds each fetched instruction stable for decode, which feeds `opcode`/`funct` into `control_unit`. It computes the next PC from `control_unit`'s `pcSrc`/`signExtSrc` when the instruction is consumed.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset. Must be word-aligned.
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, always equal to `pc`
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `instr`  out  32  held instruction; `instr[31:26]` is the opcode and `instr[5:0]` is funct
- `instr_valid`  out  1  `instr` is valid for decode
- `instr_ready`  in  1  decode/execute consumes `instr` this cycle
- `pcSrc`  in  1  from `control_unit`: take redirect (branch taken or jump)
- `signExtSrc`  in  1  from `control_unit`: 1 = jump target, 0 = branch target
- `pc`  out  32  address of the held or pending instruction
- `pc_plus4`  out  32  `pc + 4`, combinational, modulo 2^32

## Operation
- FSM states: IDLE, FETCH, WAIT, ISSUE. Encoding is binary, 2 bits.
- IDLE: entered only from reset. Goes to FETCH on the next edge.
- FETCH:
  - `imem_req`=1 with `imem_addr`=`pc`.
  - On `imem_gnt`=1, go to WAIT. Otherwise hold the request with a stable address.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`=1, capture `imem_rdata` into `instr` and go to ISSUE.
- ISSUE:
  - `instr_valid`=1. `instr` and `pc` are held stable.
  - On `instr_ready`=1, update `pc` to `next_pc`, drop `instr_valid`, and go to FETCH.
- `next_pc` is sampled in the accept cycle:
  - `pcSrc`=0: `pc_plus4`.
  - `pcSrc`=1, `signExtSrc`=0: `pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})`.
  - `pcSrc`=1, `signExtSrc`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
- Arithmetic:
  - All sums are 32-bit and wrap modulo 2^32: `pc` 32'hFFFF_FFFC + 4 gives 0.
  - Targets are word-aligned by construction; bits [1:0] of `pc` are always 0.
- `imem_rvalid` outside WAIT is ignored. This covers stale responses after reset.
- `imem_gnt` outside FETCH is ignored.
- `pcSrc`/`signExtSrc` are ignored unless ISSUE and `instr_ready` are both 1.
- Reset values:
  - state IDLE
  - `pc`=`RESET_PC`
  - `instr`=0
  - `instr_valid`=0
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
- Reset mid-operation: any outstanding fetch is abandoned immediately (asynchronous), with no output glitch beyond the reset values.

## Timing
- `imem_req` and `instr_valid` are registered state decodes; no combinational path from `imem_gnt`/`imem_rvalid` to them.
- `imem_rvalid` may arrive at the earliest one cycle after the grant cycle. Memory latency is unbounded.
- Minimum throughput is 3 cycles per instruction, with zero-wait grant, 1-cycle rvalid and immediate ready:
  - cycle n: FETCH, gnt
  - cycle n+1: WAIT, rvalid
  - cycle n+2: ISSUE, ready
  - cycle n+3: FETCH at the new `pc`
- After `rstn` deasserts, the first `imem_req` is seen in the second cycle (IDLE, then FETCH).
- `pc` changes only on the edge that ends an accepted ISSUE cycle.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (`Arith_Logic_cmd`, `BEQ_cmd`, `BNE_cmd`, `JUMP_cmd`, ...)
  - instruction field positions (opcode [31:26], imm [15:0], target [25:0], funct [5:0])
  - fetch FSM state encoding
  - `RESET_PC` default
- One sub-module, `next_pc_calc`: purely combinational; inputs `pc_plus4`, `instr`, `pcSrc`, `signExtSrc`; output `next_pc`. It is reused by any later pipelined fetch.

## Test plan
- **Reset and sequential fetch.** Set `RESET_PC`=0 and release `rstn`. Respond with gnt in the request cycle and rvalid one cycle later; hold ready high. Required: `imem_addr` sequence 0, 4, 8, 12, with `instr_valid` every 3rd cycle.
- **Taken BEQ.** Fetch at `pc`=0x40 returns `instr[15:0]`=16'hFFFE, and the accept cycle has `pcSrc`=1, `signExtSrc`=0. Required: next `imem_addr`=0x3C.
- **Jump.** At `pc`=0x1000_0010, `instr[25:0]`=26'h0000100, and the accept cycle has `pcSrc`=1, `signExtSrc`=1. Required: next address 0x1000_0400.
- **Backpressure and latency.** Withhold gnt for 4 cycles, then rvalid 5 cycles after grant, then ready low for 3 cycles. Required: `imem_addr` stable throughout; `instr` and `pc` stable while `instr_valid`=1; exactly one `pc` update.
- **Wrap and stale response.**
  - `pc`=0xFFFF_FFFC with no redirect. Required: next `pc`=0.
  - Assert `rstn`=0 during WAIT, release it, then pulse a stale rvalid while in FETCH. Required: the stale rvalid is ignored, and the fetch restarts at `RESET_PC`.
